display_arbiter: RTL and testbench

- Shares the 4-digit 7-segment display between up to NUM_REQ requesters, each supplying a 16-bit hex value.
- Round-robin arbitration; each granted value stays on the display for a minimum dwell time.
- Decodes the held value into the 28-bit segment word consumed by the digit-scan block.
- Generates the scan-rate strobe that paces the digit multiplexing.

---
 rtl/display_pkg.sv | 17 +
 rtl/hex_to_seg7.sv | 11 +
 rtl/display_arbiter.sv | 133 +++++++++++++
 tb/tb_display_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the display arbiter: segment codes (active-low
// {a,b,c,d,e,f,g}) and FSM state encodings.
package display_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_CODES [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Purely combinational hex nibble to active-low 7-segment pattern decoder.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_CODES[nibble];

endmodule

// File: rtl/display_arbiter.sv
// Round-robin sharing of the 4-digit display with minimum dwell per grant,
// plus the free-running scan strobe. Optional: LEADING_ZERO_BLANK_EN.
module display_arbiter
  import display_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int SCAN_DIV     = 50_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic [27:0]            seg_word,
  output logic                   scan_tick
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int SW = $clog2(SCAN_DIV);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [2:0]         grant_id_q, grant_id_d;
  logic [27:0]        seg_word_q, seg_word_d;
  logic [DW-1:0]      dwell_q, dwell_d;
  logic [SW-1:0]      scan_q, scan_d;

  logic [NUM_REQ-1:0] eligible;
  logic               win_valid;
  logic [2:0]         win_id;
  logic [15:0]        win_data;
  logic [6:0]         digit_raw [4];
  logic [27:0]        seg_dec;
  logic               capture;

  // A source still seeing its ack is masked so a held req is not re-captured.
  assign eligible = req & ~ack_q;

  always_comb begin
    win_valid = 1'b0;
    win_id    = grant_id_q;
    win_data  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_valid && eligible[i] && (i == (int'(grant_id_q) + k) % NUM_REQ)) begin
          win_valid = 1'b1;
          win_id    = 3'(i);
          win_data  = req_data[16*i +: 16];
        end
      end
    end
  end

  for (genvar d = 0; d < 4; d++) begin : g_dec
    hex_to_seg7 u_hex (
      .nibble (win_data[4*d +: 4]),
      .seg    (digit_raw[d])
    );
  end

  always_comb begin
    seg_dec = {digit_raw[3], digit_raw[2], digit_raw[1], digit_raw[0]};
`ifdef LEADING_ZERO_BLANK_EN
    if (win_data[15:12] == 4'h0) begin
      seg_dec[27:21] = SEG_BLANK;
      if (win_data[11:8] == 4'h0) begin
        seg_dec[20:14] = SEG_BLANK;
        if (win_data[7:4] == 4'h0) seg_dec[13:7] = SEG_BLANK;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ack_q      <= '0;
      grant_id_q <= 3'(NUM_REQ - 1);
      seg_word_q <= '1;
      dwell_q    <= '0;
      scan_q     <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      grant_id_q <= grant_id_d;
      seg_word_q <= seg_word_d;
      dwell_q    <= dwell_d;
      scan_q     <= scan_d;
    end
  end

  // Capture on an idle edge or on dwell expiry, back-to-back with no bubble.
  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    grant_id_d = grant_id_q;
    seg_word_d = seg_word_q;
    dwell_d    = dwell_q;
    scan_d     = (scan_q == SW'(SCAN_DIV - 1)) ? '0 : scan_q + 1'b1;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE: capture = win_valid;
      ST_SHOW: begin
        if (dwell_q == '0) begin
          capture = win_valid;
          if (!win_valid) state_d = ST_IDLE;
        end else begin
          dwell_d = dwell_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (capture) begin
      state_d    = ST_SHOW;
      ack_d      = NUM_REQ'(1) << win_id;
      grant_id_d = win_id;
      seg_word_d = seg_dec;
      dwell_d    = DW'(DWELL_CYCLES - 1);
    end
  end

  always_comb begin
    busy      = (state_q == ST_SHOW);
    scan_tick = (scan_q == SW'(SCAN_DIV - 1));
    ack       = ack_q;
    grant_id  = grant_id_q;
    seg_word  = seg_word_q;
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with a grant scoreboard and an
// independent segment-decode reference model.
module tb_display_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DWELL   = 8;
  localparam int SCAN    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  ack;
  logic        busy;
  logic [2:0]  grant_id;
  logic [27:0] seg_word;
  logic        scan_tick;

  int errors = 0;
  int checks = 0;
  int busyLows = 0;
  int n;

  typedef struct {
    logic [3:0]  ack;
    logic [2:0]  id;
    logic [27:0] seg;
  } exp_t;
  exp_t sbq[$];

  display_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DWELL_CYCLES (DWELL),
    .SCAN_DIV     (SCAN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .busy      (busy),
    .grant_id  (grant_id),
    .seg_word  (seg_word),
    .scan_tick (scan_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] refSeg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h01;
      4'h1: return 7'h4F;
      4'h2: return 7'h12;
      4'h3: return 7'h06;
      4'h4: return 7'h4C;
      4'h5: return 7'h24;
      4'h6: return 7'h20;
      4'h7: return 7'h0F;
      4'h8: return 7'h00;
      4'h9: return 7'h04;
      4'hA: return 7'h08;
      4'hB: return 7'h60;
      4'hC: return 7'h31;
      4'hD: return 7'h42;
      4'hE: return 7'h30;
      default: return 7'h38;
    endcase
  endfunction

  function automatic logic [27:0] refWord(input logic [15:0] d);
    logic [6:0] s3, s2, s1, s0;
    s3 = refSeg(d[15:12]);
    s2 = refSeg(d[11:8]);
    s1 = refSeg(d[7:4]);
    s0 = refSeg(d[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
    if (d[15:12] == 4'h0) s3 = 7'h7F;
    if (d[15:8] == 8'h00) s2 = 7'h7F;
    if (d[15:4] == 12'h000) s1 = 7'h7F;
`endif
    return {s3, s2, s1, s0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int cnt);
    repeat (cnt) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    req = r;
  endtask

  task automatic setData(input int i, input logic [15:0] d);
    req_data[16*i +: 16] = d;
  endtask

  task automatic pushExp(input int id, input logic [15:0] d);
    exp_t e;
    e.ack = 4'b0001 << id;
    e.id  = 3'(id);
    e.seg = refWord(d);
    sbq.push_back(e);
  endtask

  // Waits (bounded) for any ack; returns the number of negedges waited.
  task automatic waitAck(input string tag, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (!busy) busyLows++;
    end while (ack == 4'b0000 && cnt < 40);
    checkOutput({tag, "_ack_seen"}, 32'(ack != 4'b0000), 32'd1);
  endtask

  task automatic checkGrant(input string tag);
    exp_t e;
    checkOutput({tag, "_sb_nonempty"}, 32'(sbq.size() > 0), 32'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkOutput({tag, "_ack"}, 32'(ack), 32'(e.ack));
      checkOutput({tag, "_grant_id"}, 32'(grant_id), 32'(e.id));
      checkOutput({tag, "_seg_word"}, 32'(seg_word), 32'(e.seg));
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    #12;
    checkOutput("reset_seg_word", 32'(seg_word), 32'h0FFFFFFF);
    checkOutput("reset_ack", 32'(ack), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_grant_id", 32'(grant_id), 32'd3);
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: idle after reset, scan strobe every 4th cycle
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      checkOutput("s1_scan_tick", 32'(scan_tick), 32'((c % 4) == 3));
      checkOutput("s1_busy", 32'(busy), 32'd0);
    end
    checkOutput("s1_seg_word", 32'(seg_word), 32'h0FFFFFFF);
    checkOutput("s1_ack", 32'(ack), 32'd0);

    // Scenario 2: single request, zero-latency capture, dwell then idle
    setData(0, 16'h1234);
    pushExp(0, 16'h1234);
    applyStimulus(4'b0001);
    waitAck("s2", n);
    checkOutput("s2_latency", 32'(n), 32'd1);
    checkOutput("s2_seg_const", 32'(seg_word), 32'({7'h4F, 7'h12, 7'h06, 7'h4C}));
    checkGrant("s2");
    applyStimulus(4'b0000);
    tick(1);
    checkOutput("s2_ack_one_cycle", 32'(ack), 32'd0);
    tick(6);
    checkOutput("s2_busy_dwell", 32'(busy), 32'd1);
    tick(1);
    checkOutput("s2_idle", 32'(busy), 32'd0);
    checkOutput("s2_seg_kept", 32'(seg_word), 32'({7'h4F, 7'h12, 7'h06, 7'h4C}));

    // Scenario 3: three held requesters after a fresh reset
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    setData(0, 16'h89AB);
    setData(1, 16'hCDEF);
    setData(2, 16'h5670);
    pushExp(0, 16'h89AB);
    pushExp(1, 16'hCDEF);
    pushExp(2, 16'h5670);
    pushExp(0, 16'h89AB);
    pushExp(1, 16'hCDEF);
    applyStimulus(4'b0111);
    waitAck("s3_g0", n);
    checkOutput("s3_first_latency", 32'(n), 32'd1);
    checkGrant("s3_g0");
    busyLows = 0;
    for (int g = 1; g < 5; g++) begin
      waitAck("s3_gn", n);
      checkOutput("s3_spacing", 32'(n), 32'(DWELL));
      checkGrant("s3_gn");
    end
    checkOutput("s3_busy_held", 32'(busyLows), 32'd0);
    applyStimulus(4'b0000);
    tick(10);
    checkOutput("s3_idle", 32'(busy), 32'd0);

    // Scenario 4: request arriving mid-dwell waits for expiry
    setData(0, 16'h4321);
    pushExp(0, 16'h4321);
    applyStimulus(4'b0001);
    waitAck("s4_g0", n);
    checkGrant("s4_g0");
    applyStimulus(4'b0000);
    tick(3);
    setData(1, 16'hA5C3);
    pushExp(1, 16'hA5C3);
    applyStimulus(4'b0010);
    waitAck("s4_g1", n);
    checkOutput("s4_wait", 32'(n + 3), 32'(DWELL));
    checkGrant("s4_g1");
    applyStimulus(4'b0000);
    tick(10);

    // Scenario 5: async reset mid-SHOW with req[2] held
    setData(2, 16'h0F0F);
    pushExp(2, 16'h0F0F);
    applyStimulus(4'b0100);
    waitAck("s5_pre", n);
    checkGrant("s5_pre");
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("s5_rst_seg_word", 32'(seg_word), 32'h0FFFFFFF);
    checkOutput("s5_rst_busy", 32'(busy), 32'd0);
    checkOutput("s5_rst_ack", 32'(ack), 32'd0);
    checkOutput("s5_rst_grant_id", 32'(grant_id), 32'd3);
    pushExp(2, 16'h0F0F);
    @(negedge clk);
    #2 rst_n = 1'b1;
    waitAck("s5_post", n);
    checkOutput("s5_latency", 32'(n), 32'd1);
    checkGrant("s5_post");
    applyStimulus(4'b0000);
    tick(10);

    // Scenario 6: leading-zero handling
    setData(3, 16'h0050);
    pushExp(3, 16'h0050);
    applyStimulus(4'b1000);
    waitAck("s6_a", n);
    checkGrant("s6_a");
`ifdef LEADING_ZERO_BLANK_EN
    checkOutput("s6_0050_const", 32'(seg_word), 32'({7'h7F, 7'h7F, 7'h24, 7'h01}));
`else
    checkOutput("s6_0050_const", 32'(seg_word), 32'({7'h01, 7'h01, 7'h24, 7'h01}));
`endif
    applyStimulus(4'b0000);
    tick(1);
    setData(3, 16'h0000);
    pushExp(3, 16'h0000);
    applyStimulus(4'b1000);
    waitAck("s6_b", n);
    checkOutput("s6_backlog_wait", 32'(n), 32'(DWELL - 1));
    checkGrant("s6_b");
`ifdef LEADING_ZERO_BLANK_EN
    checkOutput("s6_0000_const", 32'(seg_word), 32'({7'h7F, 7'h7F, 7'h7F, 7'h01}));
`else
    checkOutput("s6_0000_const", 32'(seg_word), 32'({7'h01, 7'h01, 7'h01, 7'h01}));
`endif
    applyStimulus(4'b0000);
    tick(10);
    checkOutput("s6_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
